// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-bank arbiter: FSM state encoding, requester index
// type and the pointer wrap helper.
package mem_arb_pkg;

  localparam int MAX_NUM_REQ = 8;
  localparam int IDX_W       = $clog2(MAX_NUM_REQ);

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Index of the requester after idx, wrapping at num_req
  function automatic req_idx_t wrap_inc(input req_idx_t idx, input int num_req);
    if (int'(idx) >= num_req - 1) begin
      return '0;
    end else begin
      return idx + req_idx_t'(1);
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-bank bundle for mem_arbiter; the slave modport is the
// arbiter's view, the master modport is the requester/bank side.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_lock;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           mem_chip_en;
  logic                           mem_write_en;
  logic                           mem_read_en;
  logic [ADDR_W-1:0]              mem_write_addr;
  logic [ADDR_W-1:0]              mem_read_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic [DATA_W-1:0]              mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_lock, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_chip_en, mem_write_en,
           mem_read_en, mem_write_addr, mem_read_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_lock, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_chip_en, mem_write_en,
           mem_read_en, mem_write_addr, mem_read_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr,
// returned both one-hot and as an index.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic [NUM_REQ-1:0] grant,
  output req_idx_t           idx,
  output logic               any
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  int                 cand;
  logic [NUM_REQ-1:0] req_sh;

  // Scan requesters starting at ptr, wrapping once, and keep the first hit
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    req_sh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand   = (int'(ptr) + i) % NUM_REQ;
      req_sh = req >> cand;
      if (!any && req_sh[0]) begin
        any   = 1'b1;
        grant = ONE << cand;
        idx   = req_idx_t'(cand);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port bank between NUM_REQ requesters.
// Optional burst locking is built when MEM_ARB_LOCK_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t         state_q, state_d;
  req_idx_t           rr_ptr_q, rr_ptr_d;
  req_idx_t           pidx_q, pidx_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] grant;
  req_idx_t           gnt_idx;
  logic               gnt_any;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               rsp_live;
`ifdef MEM_ARB_LOCK_EN
  req_idx_t           owner_q, owner_d;
  logic               sel_lock;
`endif

  // Eligible requests: none during reset, only the owner while locked
  always_comb begin
    req_eff = bus.req_valid;
    if (rst) begin
      req_eff = '0;
`ifdef MEM_ARB_LOCK_EN
    end else if (state_q == LOCKED) begin
      req_eff = bus.req_valid & (ONE << owner_q);
`endif
    end else begin
      req_eff = bus.req_valid;
    end
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req_eff),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Route the granted requester's command fields
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    sel_lock  = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = bus.req_addr[i];
        sel_wdata = bus.req_wdata[i];
        sel_write = bus.req_write[i];
`ifdef MEM_ARB_LOCK_EN
        sel_lock  = bus.req_lock[i];
`endif
      end else begin
        sel_write = sel_write;
      end
    end
  end

  // Bank strobes follow the grant; address/data hold when idle
  always_comb begin
    bus.req_ready      = grant;
    bus.mem_chip_en    = gnt_any;
    bus.mem_write_en   = gnt_any & sel_write;
    bus.mem_read_en    = gnt_any & ~sel_write;
    bus.mem_write_addr = gnt_any ? sel_addr : addr_q;
    bus.mem_read_addr  = gnt_any ? sel_addr : addr_q;
    bus.mem_wdata      = gnt_any ? sel_wdata : wdata_q;
    // A read response in flight is dropped if reset lands on its return cycle
    rsp_live           = pend_q & ~rst;
    bus.rsp_valid      = rsp_live ? (ONE << pidx_q) : '0;
    bus.rsp_data       = rsp_live ? bus.mem_rdata : rsp_data_q;
  end

  // Next-state for pointer, read tracking, held bus values and the FSM
  always_comb begin
    state_d    = state_q;
    pend_d     = gnt_any & ~sel_write;
    pidx_d     = gnt_idx;
    addr_d     = gnt_any ? sel_addr : addr_q;
    wdata_d    = gnt_any ? sel_wdata : wdata_q;
    rsp_data_d = bus.rsp_data;
`ifdef MEM_ARB_LOCK_EN
    owner_d    = owner_q;
`endif
    if (gnt_any) begin
      rr_ptr_d = wrap_inc(gnt_idx, NUM_REQ);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case (state_q)
      IDLE, GRANT: begin
        state_d = gnt_any ? GRANT : IDLE;
`ifdef MEM_ARB_LOCK_EN
        if (gnt_any && sel_lock) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end else begin
          owner_d = owner_q;
        end
`endif
      end
`ifdef MEM_ARB_LOCK_EN
      LOCKED: begin
        if (gnt_any && !sel_lock) begin
          state_d = GRANT;
        end else begin
          state_d = LOCKED;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      pidx_q     <= '0;
      pend_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
`ifdef MEM_ARB_LOCK_EN
      owner_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      pidx_q     <= pidx_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
`ifdef MEM_ARB_LOCK_EN
      owner_q    <= owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency bank model;
// lock-mode expectations switch on MEM_ARB_LOCK_EN.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  mem_arbiter_if #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(16)) bus ();

  mem_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] bank [0:1023];

  // Bank model: registered read, addresses 0..3 preloaded while in reset
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 4; a++) bank[a] <= 16'h00A0 + 16'(a);
    end else if (bus.mem_chip_en) begin
      if (bus.mem_write_en) bank[bus.mem_write_addr] <= bus.mem_wdata;
      if (bus.mem_read_en) bus.mem_rdata <= bank[bus.mem_read_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_g;
  logic [3:0] lk_valid [6];
  logic [3:0] lk_lock  [6];
  logic [3:0] lk_exp   [6];

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_write = 4'h0;
    bus.req_lock  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i]  = 10'(i);
      bus.req_wdata[i] = 16'h0000;
    end
    cyc();
    #3;
    chk("rst.ready", 32'(bus.req_ready), 32'h0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst.rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("rst.strobes", 32'({bus.mem_chip_en, bus.mem_write_en, bus.mem_read_en}), 32'h0);
    chk("rst.addr", 32'({bus.mem_write_addr, bus.mem_read_addr}), 32'h0);
    chk("rst.wdata", 32'(bus.mem_wdata), 32'h0);
    cyc();
    rst = 1'b0;

    // All four read continuously from pointer 0
    for (int k = 0; k < 6; k++) begin
      #3;
      exp_g = 4'b0001 << (k % 4);
      chk("rr.ready", 32'(bus.req_ready), 32'(exp_g));
      chk("rr.strobes", 32'({bus.mem_chip_en, bus.mem_write_en, bus.mem_read_en}), 32'b101);
      chk("rr.raddr", 32'(bus.mem_read_addr), 32'(k % 4));
      if (k > 0) begin
        exp_g = 4'b0001 << ((k - 1) % 4);
        chk("rr.rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
        chk("rr.rsp_data", 32'(bus.rsp_data), 32'h00A0 + 32'((k - 1) % 4));
      end else begin
        chk("rr.rsp_first", 32'(bus.rsp_valid), 32'h0);
      end
      cyc();
    end

    bus.req_valid = 4'h0;
    #3;
    chk("idle.ready", 32'(bus.req_ready), 32'h0);
    chk("idle.strobes", 32'({bus.mem_chip_en, bus.mem_write_en, bus.mem_read_en}), 32'h0);
    chk("idle.raddr_hold", 32'(bus.mem_read_addr), 32'd1);
    chk("idle.rsp_valid", 32'(bus.rsp_valid), 32'b0010);
    chk("idle.rsp_data", 32'(bus.rsp_data), 32'h00A1);
    cyc();
    #3;
    chk("idle.rsp_clear", 32'(bus.rsp_valid), 32'h0);
    chk("idle.rsp_hold", 32'(bus.rsp_data), 32'h00A1);
    cyc();

    // Write then read-back of addr 5, then overwrite while the read returns
    bus.req_valid    = 4'b0100;
    bus.req_write    = 4'b0100;
    bus.req_addr[2]  = 10'd5;
    bus.req_wdata[2] = 16'h1234;
    #3;
    chk("wr.ready", 32'(bus.req_ready), 32'b0100);
    chk("wr.strobes", 32'({bus.mem_chip_en, bus.mem_write_en, bus.mem_read_en}), 32'b110);
    chk("wr.waddr", 32'(bus.mem_write_addr), 32'd5);
    chk("wr.wdata", 32'(bus.mem_wdata), 32'h1234);
    cyc();
    bus.req_valid   = 4'b0010;
    bus.req_write   = 4'b0000;
    bus.req_addr[1] = 10'd5;
    #3;
    chk("rdw.ready", 32'(bus.req_ready), 32'b0010);
    chk("rdw.strobes", 32'({bus.mem_chip_en, bus.mem_write_en, bus.mem_read_en}), 32'b101);
    cyc();
    bus.req_valid    = 4'b0100;
    bus.req_write    = 4'b0100;
    bus.req_wdata[2] = 16'hBEEF;
    #3;
    chk("war.ready", 32'(bus.req_ready), 32'b0100);
    chk("rdw.rsp_valid", 32'(bus.rsp_valid), 32'b0010);
    chk("rdw.rsp_data", 32'(bus.rsp_data), 32'h1234);
    cyc();
    bus.req_valid = 4'h0;
    bus.req_write = 4'h0;
    #3;
    chk("war.no_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("war.rsp_hold", 32'(bus.rsp_data), 32'h1234);
    cyc();

    // Write from req 0 and read from req 3 together, pointer at 3
    bus.req_valid    = 4'b1001;
    bus.req_write    = 4'b0001;
    bus.req_addr[0]  = 10'd7;
    bus.req_wdata[0] = 16'h0777;
    #3;
    chk("mix.ready", 32'(bus.req_ready), 32'b1000);
    chk("mix.strobes", 32'({bus.mem_chip_en, bus.mem_write_en, bus.mem_read_en}), 32'b101);
    cyc();
    #3;
    chk("mix.ready2", 32'(bus.req_ready), 32'b0001);
    chk("mix.strobes2", 32'({bus.mem_chip_en, bus.mem_write_en, bus.mem_read_en}), 32'b110);
    chk("mix.waddr", 32'(bus.mem_write_addr), 32'd7);
    chk("mix.wdata", 32'(bus.mem_wdata), 32'h0777);
    chk("mix.rsp_valid", 32'(bus.rsp_valid), 32'b1000);
    chk("mix.rsp_data", 32'(bus.rsp_data), 32'h00A3);
    cyc();

    // Reset lands on the return cycle of an accepted read
    bus.req_valid = 4'b0001;
    bus.req_write = 4'b0000;
    #3;
    chk("rrst.ready", 32'(bus.req_ready), 32'b0001);
    cyc();
    rst           = 1'b1;
    bus.req_valid = 4'b0010;
    #3;
    chk("rrst.ready_in_rst", 32'(bus.req_ready), 32'h0);
    chk("rrst.rsp_in_rst", 32'(bus.rsp_valid), 32'h0);
    chk("rrst.chip_in_rst", 32'(bus.mem_chip_en), 32'h0);
    cyc();
    rst           = 1'b0;
    bus.req_valid = 4'h0;
    #3;
    chk("rrst.rsp_after", 32'(bus.rsp_valid), 32'h0);
    chk("rrst.rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("rrst.strobes", 32'({bus.mem_chip_en, bus.mem_write_en, bus.mem_read_en}), 32'h0);
    chk("rrst.raddr", 32'(bus.mem_read_addr), 32'h0);
    chk("rrst.ptr", 32'(dut.rr_ptr_q), 32'h0);
    cyc();
    bus.req_valid = 4'hF;
    #3;
    chk("rrst.first_grant", 32'(bus.req_ready), 32'b0001);
    cyc();

    // Lone requester 3 for ten cycles
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      #3;
      chk("solo.ready", 32'(bus.req_ready), 32'b1000);
      if (k == 0) begin
        chk("solo.rsp0_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("solo.rsp0_data", 32'(bus.rsp_data), 32'h0777);
      end else begin
        chk("solo.ptr", 32'(dut.rr_ptr_q), 32'h0);
        chk("solo.rsp_data", 32'(bus.rsp_data), 32'h00A3);
      end
      cyc();
    end
    bus.req_valid = 4'h0;
    #3;
    chk("solo.last_rsp", 32'(bus.rsp_valid), 32'b1000);
    cyc();

    // Burst lock: req 1 locked writes with a gap, req 0 always asking
    bus.req_valid = 4'b0001;
    #3;
    chk("lk.pre", 32'(bus.req_ready), 32'b0001);
    cyc();
    lk_valid = '{4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0011, 4'b0001};
    lk_lock  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
`ifdef MEM_ARB_LOCK_EN
    lk_exp   = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0001};
`else
    lk_exp   = '{4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
`endif
    bus.req_write   = 4'b0010;
    bus.req_addr[1] = 10'd20;
    for (int k = 0; k < 6; k++) begin
      bus.req_valid    = lk_valid[k];
      bus.req_lock     = lk_lock[k];
      bus.req_wdata[1] = 16'(k);
      #3;
      chk("lk.ready", 32'(bus.req_ready), 32'(lk_exp[k]));
      if (k == 0) begin
        chk("lk.pre_rsp", 32'(bus.rsp_data), 32'h0777);
      end else begin
        chk("lk.excl", 32'(bus.mem_write_en & bus.mem_read_en), 32'h0);
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one single-port memory bank (`mem_model` interface semantics) between `NUM_REQ` requesters. Each cycle it grants at most one read or write, drives the bank's chip-enable, write and read strobes so that read and write are never simultaneous, and routes the one-cycle-latency read data back to the granted requester. It sits between the compute/control datapaths and each memory bank instance.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 10, bank address width
- `DATA_W`, 16, bank data width

Ports:
- `clk` in 1, single clock
- `rst` in 1, synchronous active-high reset (one clock; reset is synchronous and active-high)
- `req_valid` in NUM_REQ, per-requester access request
- `req_write` in NUM_REQ, 1 = write, 0 = read
- `req_addr` in NUM_REQ×ADDR_W, per-requester address
- `req_wdata` in NUM_REQ×DATA_W, per-requester write data
- `req_lock` in NUM_REQ, hold grant for a burst (used only with `MEM_ARB_LOCK_EN`)
- `req_ready` out NUM_REQ, one-hot grant; the access is accepted when `req_valid & req_ready`
- `rsp_valid` out NUM_REQ, one-hot; read data valid for that requester
- `rsp_data` out DATA_W, shared read-data bus
- `mem_chip_en`, `mem_write_en`, `mem_read_en` out 1, bank strobes
- `mem_write_addr`, `mem_read_addr` out ADDR_W; `mem_wdata` out DATA_W
- `mem_rdata` in DATA_W, bank read data (registered in the bank)

## Operation
- Arbitration is combinational on `req_valid`, round-robin starting at `rr_ptr`. The grant is one-hot `req_ready`, at most one bit set. With no valid request, `req_ready` = 0.
- On an accepted access, the memory strobes are driven in the same cycle. `mem_chip_en` = 1. Exactly one of `mem_write_en` or `mem_read_en` is set. The address goes to both address ports. `mem_wdata` comes from the granted requester.
- On an idle cycle, all strobes are 0; addresses and data hold their last values.
- `rr_ptr` advances to (granted index + 1) mod `NUM_REQ` on every accepted access. A wrap from `NUM_REQ-1` goes to 0.
- For reads, a 1-bit pending flag and the granted index are registered. The next cycle:
  - `rsp_valid[idx]` = 1;
  - `rsp_data` = `mem_rdata`.
- A write produces no response.
- Back-to-back accesses are allowed every cycle, including read followed by write to the same address. The read returns the old data.
- `rsp_data` holds its value when `rsp_valid` = 0.
- FSM: `IDLE` (no grant last cycle), `GRANT` (access issued), `LOCKED` (only with the macro).
  - IDLE → GRANT when any request is valid.
  - GRANT → IDLE when no request is valid.
  - GRANT → GRANT on a further request.
  - GRANT → LOCKED per Configuration.

## Timing
- Grant latency is 0 cycles from `req_valid` (combinational `req_ready`).
- Read latency: `rsp_valid` exactly 1 cycle after the accepted read.
- Throughput is 1 access per cycle.
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0;
  - all `mem_*` outputs = 0;
  - `rr_ptr` = 0, FSM = `IDLE`.
- While `rst` is high, no grant is issued.
- Reset asserted in the cycle after an accepted read: `rsp_valid` is 0 in the following cycle. The response is dropped, not replayed.
- A requester that deasserts `req_valid` without being granted is simply not served. There is no state to clean up.
- The arbiter itself never produces `mem_write_en & mem_read_en`.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - When an accepted access has `req_lock[idx]` = 1, the FSM enters `LOCKED` with owner `idx`.
  - While in `LOCKED`, only the owner can be granted. Other requesters see `req_ready` = 0 even if the owner is idle that cycle.
  - `LOCKED` exits to `GRANT`/`IDLE` on the first accepted owner access with `req_lock` = 0.
  - `rr_ptr` advances to owner+1 on exit.
- Not defined:
  - `req_lock` is ignored.
  - `LOCKED` state and owner register are not synthesized.
  - Arbitration is pure round-robin.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (`IDLE`, `GRANT`, `LOCKED`);
  - `MAX_NUM_REQ` = 8;
  - the requester index type (`$clog2(MAX_NUM_REQ)` bits).
- One sub-module, `rr_picker`: combinational round-robin priority select. Inputs are the request vector and the pointer. Outputs are the one-hot grant and the index.

## Test plan
- All 4 requesters assert reads to addr 0..3 (preloaded 0xA0..0xA3) continuously from `rr_ptr` = 0. Required:
  - grants 0,1,2,3,0… on consecutive cycles;
  - each `rsp_valid` one cycle later with the matching data.
- Req 2 writes 0x1234 to addr 5, and req 1 reads addr 5 in the next cycle. Required:
  - the write is granted first;
  - the read returns 0x1234.
- Same-cycle write from req 0 and read from req 3 with `rr_ptr` = 3. Required:
  - req 3 is granted;
  - no cycle has both `mem_write_en` and `mem_read_en`.
- Reset is pulsed one cycle after an accepted read. Required:
  - `rsp_valid` stays 0;
  - after reset, `rr_ptr` = 0 and all strobes are 0.
- `MEM_ARB_LOCK_EN`: req 1 issues 3 locked writes, with an idle gap, while req 0 requests continuously. Required:
  - req 0 is not granted until req 1's unlocked access;
  - req 0 is then granted the next cycle.
- A single requester (req 3) is valid for 10 cycles. Required:
  - granted every cycle;
  - `rr_ptr` wraps to 0 each time.
